// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the XOR parity link (receiver and transmitter).
//   state_e      : frame FSM states
//   PARITY_EVEN  : parity bit = XOR of data bits
//   PARITY_ODD   : parity bit = ~XOR of data bits
// -----------------------------------------------------------------------------
package parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

endpackage : parity_pkg

// File: rtl/serial_parity_checker_if.sv
// -----------------------------------------------------------------------------
// serial_parity_checker_if
// Bundle of the serial input stream and the parallel result of the checker.
//   bit_valid, bit_in, sof                              : serial side
//   data_out, out_valid, parity_err, busy, frame_abort  : word side
// master : drives the serial stream, observes the results
// slave  : the checker itself
// -----------------------------------------------------------------------------
interface serial_parity_checker_if #(
    parameter int DATA_W = 8
);

    logic              bit_valid;
    logic              bit_in;
    logic              sof;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              parity_err;
    logic              busy;
    logic              frame_abort;

    modport master (
        output bit_valid, bit_in, sof,
        input  data_out, out_valid, parity_err, busy, frame_abort
    );

    modport slave (
        input  bit_valid, bit_in, sof,
        output data_out, out_valid, parity_err, busy, frame_abort
    );

endinterface : serial_parity_checker_if

// File: rtl/parity_accum.sv
// -----------------------------------------------------------------------------
// parity_accum
// Running XOR register. Priority: clear > load > update.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : acc <= 0
//   load_i     : acc <= bit_i (first bit of a new frame)
//   upd_i      : acc <= acc ^ bit_i
//   bit_i      : incoming bit
//   acc_o      : current accumulated parity
// -----------------------------------------------------------------------------
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic load_i,
    input  logic upd_i,
    input  logic bit_i,
    output logic acc_o
);

    logic acc_q;
    logic acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = 1'b0;
        end else if (load_i) begin
            acc_d = bit_i;
        end else if (upd_i) begin
            acc_d = acc_q ^ bit_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule : parity_accum

// File: rtl/serial_parity_checker.sv
// -----------------------------------------------------------------------------
// serial_parity_checker
// Deserialises DATA_W data bits (LSB first) followed by one parity bit and
// reports the word together with a parity error flag.
//   clk, rst_n : clock, async active-low reset
//   bus        : serial_parity_checker_if slave (stream in, word/status out)
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | no frame open; only a valid sof bit starts one
// ST_DATA   | collecting data bits 1..DATA_W-1
// ST_PARITY | all data bits held; next valid bit is the parity bit
// -----------------------------------------------------------------------------
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = PARITY_EVEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_parity_checker_if.slave  bus
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic            ODD_BIT  = (ODD_PARITY == PARITY_ODD);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              out_valid_q, out_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              busy_q, busy_d;
    logic              abort_q, abort_d;

    logic              acc_clr;
    logic              acc_load;
    logic              acc_upd;
    logic              acc;

    parity_accum u_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (acc_clr),
        .load_i (acc_load),
        .upd_i  (acc_upd),
        .bit_i  (bus.bit_in),
        .acc_o  (acc)
    );

    // Bits enter at the MSB and shift right, so after DATA_W accepted bits
    // the first one (bit 0) has arrived at the LSB.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        parity_err_d = parity_err_q;
        out_valid_d  = 1'b0;
        abort_d      = 1'b0;
        acc_clr      = 1'b0;
        acc_load     = 1'b0;
        acc_upd      = 1'b0;

        if (bus.bit_valid) begin
            if (bus.sof) begin
                // A sof always opens a new frame; an open one is thrown away.
                abort_d  = (state_q != ST_IDLE);
                shift_d  = {bus.bit_in, {(DATA_W-1){1'b0}}};
                cnt_d    = CNT_W'(1);
                acc_load = 1'b1;
                state_d  = ST_DATA;
            end else begin
                case (state_q)
                    ST_DATA: begin
                        shift_d = {bus.bit_in, shift_q[DATA_W-1:1]};
                        acc_upd = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_err_d = bus.bit_in ^ acc ^ ODD_BIT;
                        data_out_d   = shift_q;
                        out_valid_d  = 1'b1;
                        cnt_d        = '0;
                        acc_clr      = 1'b1;
                        state_d      = ST_IDLE;
                    end
                    default: begin
                        // stray bit outside a frame is dropped
                    end
                endcase
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            data_out_q   <= '0;
            out_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            out_valid_q  <= out_valid_d;
            parity_err_q <= parity_err_d;
            busy_q       <= busy_d;
            abort_q      <= abort_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.parity_err  = parity_err_q;
    assign bus.busy        = busy_q;
    assign bus.frame_abort = abort_q;

endmodule : serial_parity_checker

// File: tb/tb_serial_parity_checker.sv
// -----------------------------------------------------------------------------
// tb_serial_parity_checker
// Even- and odd-parity checkers fed the same serial stream, compared every
// cycle against a frame-level model, plus literal expectations on key frames.
// -----------------------------------------------------------------------------
module tb_serial_parity_checker;

    logic clk = 1'b0;
    logic rst_n;
    logic vld, bin, sf;

    always #5 clk = ~clk;

    serial_parity_checker_if #(.DATA_W(8)) if_e ();
    serial_parity_checker_if #(.DATA_W(8)) if_o ();

    assign if_e.bit_valid = vld;
    assign if_e.bit_in    = bin;
    assign if_e.sof       = sf;
    assign if_o.bit_valid = vld;
    assign if_o.bit_in    = bin;
    assign if_o.sof       = sf;

    serial_parity_checker #(.DATA_W(8), .ODD_PARITY(0)) u_even (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_e)
    );

    serial_parity_checker #(.DATA_W(8), .ODD_PARITY(1)) u_odd (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_o)
    );

    int vectors    = 0;
    int miscompares = 0;
    int ov_seen    = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- frame-level reference model ----------------
    logic [7:0] m_data;
    logic       m_ov, m_err_e, m_err_o, m_busy, m_abort, m_in;
    logic       fr[$];

    function automatic void model_reset();
        m_data  = '0;
        m_ov    = 1'b0;
        m_err_e = 1'b0;
        m_err_o = 1'b0;
        m_busy  = 1'b0;
        m_abort = 1'b0;
        m_in    = 1'b0;
        fr.delete();
    endfunction

    function automatic void model_step();
        int         ones;
        logic [7:0] w;
        m_ov    = 1'b0;
        m_abort = 1'b0;
        if (vld) begin
            if (sf) begin
                m_abort = m_in;
                fr.delete();
                fr.push_back(bin);
                m_in = 1'b1;
            end else if (m_in) begin
                fr.push_back(bin);
                if (fr.size() == 9) begin
                    ones = 0;
                    w    = '0;
                    for (int i = 0; i < 9; i++) if (fr[i]) ones++;
                    for (int i = 0; i < 8; i++) w[i] = fr[i];
                    m_data  = w;
                    m_err_e = (ones % 2) == 1;
                    m_err_o = (ones % 2) == 0;
                    m_ov    = 1'b1;
                    m_in    = 1'b0;
                    fr.delete();
                end
            end
        end
        m_busy = m_in;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("even.data_out",    if_e.data_out,    m_data);
            chk("even.out_valid",   if_e.out_valid,   m_ov);
            chk("even.parity_err",  if_e.parity_err,  m_err_e);
            chk("even.busy",        if_e.busy,        m_busy);
            chk("even.frame_abort", if_e.frame_abort, m_abort);
            chk("odd.data_out",     if_o.data_out,    m_data);
            chk("odd.out_valid",    if_o.out_valid,   m_ov);
            chk("odd.parity_err",   if_o.parity_err,  m_err_o);
            chk("odd.busy",         if_o.busy,        m_busy);
            chk("odd.frame_abort",  if_o.frame_abort, m_abort);
            if (if_e.out_valid) ov_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_bit(input logic v, input logic b, input logic s);
        @(negedge clk);
        vld = v;
        bin = b;
        sf  = s;
    endtask

    task automatic idle(input int n);
        repeat (n) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic send_frame(input logic [7:0] w, input logic p, input int gap_max);
        for (int i = 0; i < 9; i++) begin
            send_bit(1'b1, (i < 8) ? w[i] : p, i == 0);
            if (gap_max > 0) idle($urandom_range(1, gap_max));
        end
    endtask

    // result of the frame whose parity bit was driven one negedge earlier
    task automatic pin(input string tag, input logic [7:0] d, input logic ee, input logic eo);
        chk({tag, ".ov"},      if_e.out_valid,  1'b1);
        chk({tag, ".data"},    if_e.data_out,   d);
        chk({tag, ".err_e"},   if_e.parity_err, ee);
        chk({tag, ".err_o"},   if_o.parity_err, eo);
        chk({tag, ".model"},   m_data,          d);
        chk({tag, ".model_e"}, m_err_e,         ee);
    endtask

    initial begin
        int base;
        logic [7:0] w5a;
        rst_n = 1'b0;
        vld   = 1'b0;
        bin   = 1'b0;
        sf    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.busy",     if_e.busy,     0);
        chk("rst.data_out", if_o.data_out, 0);
        chk("rst.ov",       if_e.out_valid, 0);
        rst_n = 1'b1;

        // contiguous frames, even and odd results
        send_frame(8'hA5, 1'b0, 0); idle(1); pin("a5p0", 8'hA5, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b1, 0); idle(1); pin("a5p1", 8'hA5, 1'b1, 1'b0);
        send_frame(8'h01, 1'b1, 0); idle(1); pin("01p1", 8'h01, 1'b0, 1'b1);
        send_frame(8'h01, 1'b0, 0); idle(1); pin("01p0", 8'h01, 1'b1, 1'b0);
        send_frame(8'h00, 1'b0, 0); idle(1); pin("00p0", 8'h00, 1'b0, 1'b1);

        // stray bits while idle, then a gappy frame
        repeat (3) begin
            send_bit(1'b1, 1'b1, 1'b0);
            idle(1);
        end
        base = ov_seen;
        send_frame(8'h3C, 1'b0, 5);
        idle(2);
        chk("gap.ov_count", ov_seen - base, 1);
        chk("gap.data",     if_e.data_out, 8'h3C);
        chk("gap.err_e",    if_e.parity_err, 0);

        // abort at data bit 5 of 0xFF, restart with 0x5A
        base = ov_seen;
        w5a  = 8'h5A;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1, i == 0);
        send_bit(1'b1, w5a[0], 1'b1);
        send_bit(1'b1, w5a[1], 1'b0);
        chk("abort.pulse", if_e.frame_abort, 1);
        chk("abort.busy",  if_e.busy, 1);
        chk("abort.hold",  if_e.data_out, 8'h3C);
        for (int i = 2; i < 8; i++) send_bit(1'b1, w5a[i], 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        idle(1);
        pin("5a", 8'h5A, 1'b0, 1'b1);
        idle(1);
        chk("abort.ov_count", ov_seen - base, 1);

        // async reset mid-frame
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, i == 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        vld   = 1'b0;
        #1;
        chk("arst.busy",  if_e.busy, 0);
        chk("arst.data",  if_e.data_out, 0);
        chk("arst.err_o", if_o.parity_err, 0);
        chk("arst.ov",    if_o.out_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h81, 1'b0, 0); idle(1); pin("81p0", 8'h81, 1'b0, 1'b1);

        // back-to-back frames
        send_frame(8'hC3, 1'b1, 0);
        send_frame(8'h5A, 1'b0, 0);
        idle(1);
        pin("b2b", 8'h5A, 1'b0, 1'b1);

        // random stream
        repeat (800) begin
            send_bit(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 11) == 0));
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serial_parity_checker
